montgomery_seq: RTL and testbench
=================================

Name: montgomery_seq

Overview:
- Sequencer that drives the 514-bit carry-save multi-precision adder through a full Montgomery multiplication R = A·B·2^-N mod M.
- Walks B bit-serially, issuing add-A / conditional add-M / shift steps.
- Then issues the 5-chunk carry-propagate resolve, then repeated chunked subtract passes until the adder reports completion.
- Sits between the top-level start/done interface and the adder control pins; the operand mux in front of the adder's in_a is selected by this block.

Parameters:
- N_BITS, 512, operand width; number of B bits iterated.
- CNT_W, 10, width of the bit counter; must satisfy 2^CNT_W > N_BITS.
- MAX_SUB, 3, maximum subtract passes before error is flagged.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- b_in  in  N_BITS  multiplier B; latched on accepted start
- c_zero  in  1  adder sum LSB (odd flag) of current carry-save value
- sub_done  in  1  adder subtract-finished flag
- add_sel  out  2  operand mux select for adder in_a: 0=zero, 1=A, 2=M, 3=two's-complement M
- enable_c  out  1  adder carry-save load
- shift  out  1  adder carry-save right shift
- subtract  out  1  adder subtract mode
- chunk_sel  out  4  adder chunk index; 0..4 active, 8 = idle/freeze
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  high with done if MAX_SUB exceeded; held until next start

Behaviour:
- Reset is synchronous, active-low; clock is clk. On reset all outputs are 0 except chunk_sel=8, and the FSM goes to IDLE.
- Reset mid-operation aborts immediately. No done pulse is produced.
- States: IDLE, ADD_A, ADD_M, SHIFT, RESOLVE, SUB, FIN.
- IDLE: start=1 latches b_in into the B shift register, clears bit counter and sub-pass counter, clears error, sets busy. Next state is ADD_A. start in any other state is ignored.
- ADD_A (1 cycle):
  - add_sel=1.
  - enable_c = B[0].
  - Next state ADD_M.
- ADD_M (1 cycle):
  - c_zero is valid here, reflecting the registered value after ADD_A.
  - add_sel=2; enable_c = c_zero.
  - Next state SHIFT.
- SHIFT (1 cycle):
  - shift=1.
  - B register shifts right 1; bit counter increments.
  - If the counter reaches N_BITS-1 before incrementing, next state is RESOLVE with chunk_sel=0. Otherwise next state is ADD_A.
- Iteration timing: exactly 3 cycles per bit. chunk_sel=8 throughout iteration so the adder's chunk carry register is frozen.
- RESOLVE:
  - subtract=0, enable_c=0, shift=0.
  - chunk_sel steps 0,1,2,3,4 on consecutive cycles (5 cycles).
  - After chunk 4: next state SUB, chunk_sel=0, sub-pass counter = 1.
- SUB:
  - subtract=1, add_sel=3.
  - chunk_sel steps 0..4 and wraps 4 -> 0.
  - sub_done is evaluated only in the cycle chunk_sel=4. If sub_done=1, next state is FIN.
  - Otherwise at chunk 4, sub-pass counter increments. If it would exceed MAX_SUB, set error and go to FIN.
  - sub_done asserted while chunk_sel != 4 is ignored.
- FIN (1 cycle):
  - done=1, subtract=0, chunk_sel=8.
  - busy drops on the next cycle; next state IDLE.
- Control exclusivity: enable_c, shift and subtract are mutually exclusive in every cycle. add_sel=0 whenever enable_c=0 and subtract=0.
- Total latency, start accepted to done: 1 + 3·N_BITS + 5 + 5·k cycles, where k = number of subtract passes (k ≥ 1).

Test Plan:
- Reset mid-iteration:
  - Assert resetn=0 during SHIFT of bit 100.
  - Next cycle: all outputs 0, chunk_sel=8, busy=0, no done pulse.
  - A fresh start is then accepted normally.
- B=0, c_zero forced 0:
  - enable_c is never asserted during iteration.
  - Exactly 512 shift pulses occur.
  - RESOLVE shows chunk_sel 0..4.
  - sub_done=1 at first chunk 4 gives done at cycle 1+1536+5+5 = 1547.
- B=1, c_zero=1 on bit 0 only:
  - ADD_A and ADD_M both assert enable_c in bit 0, with add_sel 1 then 2.
  - No enable_c in later bits.
- Subtract loop:
  - Hold sub_done=0 for 2 passes, assert on pass 3 at chunk 4.
  - done arrives 10 cycles later than the single-pass case; error=0.
  - A sub_done pulse at chunk 2 must be ignored.
- MAX_SUB overflow:
  - Hold sub_done=0 throughout.
  - After 3 passes, done=1 with error=1; error holds until the next start.
- start while busy:
  - Pulse start at iteration bit 10 with a different b_in.
  - No restart occurs; the latched B is unchanged; cycle count is unchanged.

Source files
------------

// File: rtl/montgomery_seq.sv
// montgomery_seq
// ---------------
// Control sequencer for a Montgomery multiplication R = A*B*2^-N mod M. It
// drives a 514-bit carry-save multi-precision adder. Each bit of B takes
// three cycles: add A, conditionally add M, then shift. After the last bit,
// a 5-chunk carry-propagate resolve runs. Then chunked subtract passes
// repeat until the adder reports sub_done, or until the pass limit is hit.
//
// Ports
//   clk        clock
//   resetn     synchronous active-low reset
//   start      one-cycle request, honoured only while idle
//   b_in       multiplier B, captured when start is accepted
//   c_zero     adder sum LSB (odd flag) of the current carry-save value
//   sub_done   adder subtract-finished flag, looked at only on chunk 4
//   add_sel    adder in_a mux: 0=zero 1=A 2=M 3=-M
//   enable_c   adder carry-save load
//   shift      adder carry-save right shift
//   subtract   adder subtract mode
//   chunk_sel  adder chunk index, 0..4 active, 8 = idle/freeze
//   busy       high from accepted start until the cycle after done
//   done       one-cycle completion pulse
//   error      subtract pass limit exceeded; held until the next start
module montgomery_seq #(
  parameter int N_BITS  = 512,
  parameter int CNT_W   = 10,
  parameter int MAX_SUB = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N_BITS-1:0] b_in,
  input  logic              c_zero,
  input  logic              sub_done,
  output logic [1:0]        add_sel,
  output logic              enable_c,
  output logic              shift,
  output logic              subtract,
  output logic [3:0]        chunk_sel,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int SUB_W = $clog2(MAX_SUB + 1);

  localparam logic [3:0]       CHUNK_FREEZE = 4'd8;
  localparam logic [3:0]       CHUNK_LAST   = 4'd4;
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(N_BITS - 1);
  localparam logic [SUB_W-1:0] SUB_LIMIT    = SUB_W'(MAX_SUB);

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_M    = 2'd2;
  localparam logic [1:0] SEL_NEGM = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADD_A,
    ADD_M,
    SHIFT,
    RESOLVE,
    SUB,
    FIN
  } state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [3:0]        chunk_q, chunk_d;
  logic              error_q, error_d;

  // State register together with the datapath registers the FSM owns. Reset
  // parks chunk_sel at the freeze value, so the adder's chunk carry register
  // holds its value while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      b_q       <= '0;
      bit_cnt_q <= '0;
      sub_cnt_q <= '0;
      chunk_q   <= CHUNK_FREEZE;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      bit_cnt_q <= bit_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      chunk_q   <= chunk_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic. The bit counter is compared before it increments, so
  // the SHIFT of bit N_BITS-1 is the one that leaves the iteration. The chunk
  // index is registered, so each transition loads the index that the next
  // state starts on.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    bit_cnt_d = bit_cnt_q;
    sub_cnt_d = sub_cnt_q;
    chunk_d   = chunk_q;
    error_d   = error_q;

    unique case (state_q)
      IDLE: begin
        chunk_d = CHUNK_FREEZE;
        if (start) begin
          b_d       = b_in;
          bit_cnt_d = '0;
          sub_cnt_d = '0;
          error_d   = 1'b0;
          state_d   = ADD_A;
        end
      end

      ADD_A: state_d = ADD_M;

      ADD_M: state_d = SHIFT;

      SHIFT: begin
        b_d       = b_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          chunk_d = '0;
          state_d = RESOLVE;
        end else begin
          state_d = ADD_A;
        end
      end

      RESOLVE: begin
        if (chunk_q == CHUNK_LAST) begin
          chunk_d   = '0;
          sub_cnt_d = SUB_W'(1);
          state_d   = SUB;
        end else begin
          chunk_d = chunk_q + 4'd1;
        end
      end

      // sub_done is only meaningful once the top chunk has been processed.
      // A pass that ends without it starts another pass, unless this was
      // already the last permitted pass.
      SUB: begin
        if (chunk_q == CHUNK_LAST) begin
          if (sub_done) begin
            chunk_d = CHUNK_FREEZE;
            state_d = FIN;
          end else if (sub_cnt_q == SUB_LIMIT) begin
            error_d = 1'b1;
            chunk_d = CHUNK_FREEZE;
            state_d = FIN;
          end else begin
            sub_cnt_d = sub_cnt_q + SUB_W'(1);
            chunk_d   = '0;
          end
        end else begin
          chunk_d = chunk_q + 4'd1;
        end
      end

      FIN: begin
        chunk_d = CHUNK_FREEZE;
        state_d = IDLE;
      end

      default: begin
        chunk_d = CHUNK_FREEZE;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. The operand mux is forced to zero whenever the adder is
  // neither loading nor subtracting. This keeps in_a quiet on idle cycles.
  always_comb begin
    add_sel   = SEL_ZERO;
    enable_c  = 1'b0;
    shift     = 1'b0;
    subtract  = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    chunk_sel = chunk_q;
    error     = error_q;

    unique case (state_q)
      ADD_A: begin
        enable_c = b_q[0];
        add_sel  = b_q[0] ? SEL_A : SEL_ZERO;
      end
      ADD_M: begin
        enable_c = c_zero;
        add_sel  = c_zero ? SEL_M : SEL_ZERO;
      end
      SHIFT: shift = 1'b1;
      SUB: begin
        subtract = 1'b1;
        add_sel  = SEL_NEGM;
      end
      FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_montgomery_seq.sv
// tb_montgomery_seq
// ------------------
// Directed bench for montgomery_seq. Each operation is driven cycle by
// cycle. The bench plays the adder's c_zero and sub_done from its own
// schedule. Every output is compared against the cycle timing it expects
// (3 cycles per bit, 5 resolve cycles, 5 cycles per subtract pass). The
// expected done cycle and error flag are queued when start is driven and
// popped when done appears.
module tb_montgomery_seq;

  localparam int NB = 512;
  localparam int CW = 10;
  localparam int MS = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [NB-1:0] b_in;
  logic          c_zero;
  logic          sub_done;
  logic [1:0]    add_sel;
  logic          enable_c;
  logic          shift;
  logic          subtract;
  logic [3:0]    chunk_sel;
  logic          busy;
  logic          done;
  logic          error;

  typedef struct {
    int   cycle;
    logic err;
  } exp_t;

  exp_t sb[$];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  montgomery_seq #(.N_BITS(NB), .CNT_W(CW), .MAX_SUB(MS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .b_in      (b_in),
    .c_zero    (c_zero),
    .sub_done  (sub_done),
    .add_sel   (add_sel),
    .enable_c  (enable_c),
    .shift     (shift),
    .subtract  (subtract),
    .chunk_sel (chunk_sel),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Idle cycles: busy and done must stay low, and error must keep expErr.
  task automatic idleCycles(input int n, input logic expErr, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (busy !== 1'b0 || done !== 1'b0 || error !== expErr) bad++;
    end
    checkOutput(tag, bad, 0);
  endtask

  // One operation. Entered and left at posedge+2.
  // czBit: bit whose ADD_M sees c_zero=1 (-1 none).
  // passOk: pass that reports sub_done at chunk 4 (0 = never).
  // glitchPass: pass that gets a sub_done pulse at chunk 2 (0 = none).
  // startBit: bit whose ADD_A sees a stray start with ~b (-1 none).
  // resetBit: bit whose SHIFT sees resetn=0 (-1 none).
  task automatic applyStimulus(input logic [NB-1:0] b, input int czBit, input int passOk,
                               input int glitchPass, input int startBit, input int resetBit);
    int   j, phase, bitI, s, pass, ch, k, limit;
    int   shifts = 0, iterErr = 0, resErr = 0, subErr = 0, finErr = 0;
    int   exclErr = 0, busyErr = 0, doneCycle = 0;
    bit   iter, aborted = 0, doneSeen = 0;
    logic doneErr = 1'b0, expErr, expEn;
    logic [1:0] expSel;
    exp_t e;

    expErr = !(passOk >= 1 && passOk <= MS);
    k      = expErr ? MS : passOk;
    e.cycle = 1 + 3 * NB + 5 + 5 * k;
    e.err   = expErr;
    sb.push_back(e);
    limit = 3 * NB + 5 + 5 * (MS + 1) + 5;

    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    j = 1;
    while (j <= limit) begin
      #1;
      iter  = (j <= 3 * NB);
      phase = (j - 1) % 3;
      bitI  = (j - 1) / 3;
      s     = j - 3 * NB - 6;
      pass  = (s >= 0) ? s / 5 + 1 : 0;
      ch    = (s >= 0) ? s % 5 : 0;
      c_zero   = iter && phase == 1 && bitI == czBit;
      sub_done = (s >= 0) && ((ch == 4 && pass == passOk) || (ch == 2 && pass == glitchPass));
      start    = iter && phase == 0 && bitI == startBit;
      if (start) b_in = ~b;
      if (iter && phase == 2 && bitI == resetBit) begin
        resetn  = 1'b0;
        aborted = 1;
      end
      #1;
      if (int'(enable_c) + int'(shift) + int'(subtract) > 1) exclErr++;
      if (enable_c === 1'b0 && subtract === 1'b0 && add_sel !== 2'd0) exclErr++;
      if (busy !== 1'b1) busyErr++;
      if (done === 1'b1) begin
        if (chunk_sel !== 4'd8 || subtract !== 1'b0 || enable_c !== 1'b0 || shift !== 1'b0) finErr++;
        doneSeen  = 1;
        doneCycle = j;
        doneErr   = error;
        break;
      end
      if (error !== 1'b0) busyErr++;
      if (iter) begin
        case (phase)
          0:       begin expEn = b[bitI];      expSel = expEn ? 2'd1 : 2'd0; end
          1:       begin expEn = (bitI == czBit); expSel = expEn ? 2'd2 : 2'd0; end
          default: begin expEn = 1'b0;         expSel = 2'd0; end
        endcase
        if (enable_c !== expEn || add_sel !== expSel || shift !== (phase == 2) ||
            subtract !== 1'b0 || chunk_sel !== 4'd8) iterErr++;
        if (shift === 1'b1) shifts++;
      end else if (j <= 3 * NB + 5) begin
        if (chunk_sel !== 4'(j - 3 * NB - 1) || subtract !== 1'b0 || enable_c !== 1'b0 ||
            shift !== 1'b0 || add_sel !== 2'd0) resErr++;
      end else begin
        if (chunk_sel !== 4'(ch) || subtract !== 1'b1 || add_sel !== 2'd3) subErr++;
      end
      if (aborted) break;
      @(posedge clk);
      j++;
    end
    c_zero   = 1'b0;
    sub_done = 1'b0;
    start    = 1'b0;

    if (aborted) begin
      @(posedge clk);
      #2;
      checkOutput("reset_abort_outputs",
                  32'({add_sel, enable_c, shift, subtract, chunk_sel, busy, done, error}),
                  32'({2'd0, 3'b000, 4'd8, 3'b000}));
      checkOutput("reset_abort_iter", iterErr, 0);
      resetn = 1'b1;
      void'(sb.pop_front());
      return;
    end

    checkOutput("done_seen", 32'(doneSeen), 32'd1);
    e = sb.pop_front();
    if (doneSeen) begin
      checkOutput("latency", doneCycle, e.cycle);
      checkOutput("error_flag", 32'(doneErr), 32'(e.err));
    end
    checkOutput("shift_pulses", shifts, NB);
    checkOutput("iteration_outputs", iterErr, 0);
    checkOutput("resolve_chunks", resErr, 0);
    checkOutput("sub_chunks", subErr, 0);
    checkOutput("fin_outputs", finErr, 0);
    checkOutput("exclusivity", exclErr, 0);
    checkOutput("busy_held", busyErr, 0);
    @(posedge clk);
    #2;
    checkOutput("busy_drop", 32'({busy, done, error}), 32'({2'b00, e.err}));
  endtask

  initial begin
    logic [NB-1:0] pattern;
    pattern  = {16{32'hA5C3_0F96}};
    resetn   = 1'b0;
    start    = 1'b0;
    b_in     = '0;
    c_zero   = 1'b0;
    sub_done = 1'b0;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_outputs",
                32'({add_sel, enable_c, shift, subtract, chunk_sel, busy, done, error}),
                32'({2'd0, 3'b000, 4'd8, 3'b000}));
    resetn = 1'b1;
    idleCycles(2, 1'b0, "idle_after_reset");

    $display("[TB] B=0, single subtract pass");
    applyStimulus('0, -1, 1, 0, -1, -1);

    $display("[TB] B=1, c_zero on bit 0");
    applyStimulus(NB'(1), 0, 1, 0, -1, -1);

    $display("[TB] subtract loop, done on pass 3, glitch at chunk 2");
    applyStimulus(pattern, 5, 3, 1, -1, -1);

    $display("[TB] subtract overflow");
    applyStimulus(pattern, -1, 0, 0, -1, -1);
    idleCycles(6, 1'b1, "error_held");

    $display("[TB] start while busy");
    applyStimulus(pattern, 7, 2, 0, 10, -1);

    $display("[TB] reset mid-iteration");
    applyStimulus(pattern, -1, 1, 0, -1, 100);
    idleCycles(8, 1'b0, "no_done_after_abort");

    $display("[TB] fresh start after abort");
    applyStimulus(~pattern, 3, 1, 0, -1, -1);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
